// File: rtl/i2c_lcm_pkg.sv
// Shared types and widths for the LCM configuration-link responder.
package i2c_lcm_pkg;

    localparam int LCM_REG_ADDR_W = 6;
    localparam int LCM_DATA_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } lcm_state_t;

endpackage

// File: rtl/i2c_bus_sampler.sv
// Synchronises raw SCL/SDA pins and produces one-cycle SCL edge and START/STOP pulses.
// Latency: pulses appear 2 clk after the pin edge; no backpressure (free-running sampler).
module i2c_bus_sampler (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // [0],[1] are the synchroniser; [2] holds the previous synchronised level.
    logic [2:0] r_scl_sync;
    logic [2:0] r_sda_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], i_scl};
            r_sda_sync <= {r_sda_sync[1:0], i_sda};
        end
    end

    assign o_sda      = r_sda_sync[1];
    assign o_scl_rise = r_scl_sync[1] & ~r_scl_sync[2];
    assign o_scl_fall = ~r_scl_sync[1] & r_scl_sync[2];
    assign o_start    = r_sda_sync[2] & ~r_sda_sync[1] & r_scl_sync[1] & r_scl_sync[2];
    assign o_stop     = ~r_sda_sync[2] & r_sda_sync[1] & r_scl_sync[1] & r_scl_sync[2];

endmodule

// File: rtl/i2c_lcm_register_responder.sv
// Responder end of the LCM configuration link: decodes {0,reg,rw}+data frames into a register file.
// Latency: SDA drive changes 3 clk after the SCL pin fall; writes commit 3 clk after the 8th SCL rise.
module i2c_lcm_register_responder
    import i2c_lcm_pkg::*;
#(
    parameter int                    NUM_REGS    = 25,
    parameter logic [LCM_DATA_W-1:0] RESET_VALUE = 8'h00
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scl_in,
    input  logic                      sda_in,
    output logic                      sda_oe,
    input  logic                      clear_error,
    input  logic [LCM_REG_ADDR_W-1:0] cfg_rd_addr,
    output logic [LCM_DATA_W-1:0]     cfg_rd_data,
    output logic                      reg_wr_en,
    output logic [LCM_REG_ADDR_W-1:0] reg_wr_addr,
    output logic [LCM_DATA_W-1:0]     reg_wr_data,
    output logic                      busy,
    output logic                      frame_error
);

    localparam logic [6:0] LP_NUM_REGS = 7'(NUM_REGS);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    lcm_state_t                r_state, w_state_nxt;
    logic [3:0]                r_bit_cnt;
    logic                      r_ack_phase;
    logic [LCM_DATA_W-1:0]     r_shift;
    logic                      r_rw;
    logic [6:0]                r_reg_ptr;
    logic [LCM_DATA_W-1:0]     r_regs [NUM_REGS];
    logic                      r_sda_oe, r_busy, r_frame_error;
    logic                      r_wr_en;
    logic [LCM_REG_ADDR_W-1:0] r_wr_addr;
    logic [LCM_DATA_W-1:0]     r_wr_data;

    logic [LCM_DATA_W-1:0] w_byte, w_ptr_byte, w_cfg_byte;
    logic [6:0]            w_addr_ptr, w_ptr_inc;
    logic                  w_addr_ok, w_byte_done, w_in_byte, w_rd_continue, w_load_rd;
    logic                  w_sda_oe_nxt, w_commit, w_err_set;

    i2c_bus_sampler u_sampler (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_byte        = {r_shift[6:0], w_sda};
    assign w_addr_ptr    = {1'b0, r_shift[5:0]};
    assign w_addr_ok     = !r_shift[6] && (w_addr_ptr < LP_NUM_REGS);
    assign w_ptr_inc     = r_reg_ptr + 7'd1;
    assign w_byte_done   = w_scl_rise && (r_bit_cnt == 4'd7);
    assign w_rd_continue = !w_sda && (w_ptr_inc < LP_NUM_REGS);
    assign w_load_rd     = (w_state_nxt == ST_RD_DATA) && (r_state != ST_RD_DATA);

    // START/STOP arrive with SCL high, so the rise just before them is not a real bit:
    // a byte is only partial once at least one full bit precedes that rise.
    assign w_in_byte = ((r_state == ST_ADDR) || (r_state == ST_WR_DATA) || (r_state == ST_RD_DATA))
                       && (r_bit_cnt >= 4'd2) && (r_bit_cnt <= 4'd7);

    always_comb begin
        w_ptr_byte = RESET_VALUE;
        w_cfg_byte = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_reg_ptr == 7'(i))   w_ptr_byte = r_regs[i];
            if (cfg_rd_addr == 6'(i)) w_cfg_byte = r_regs[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
        end else begin
            case (r_state)
                ST_ADDR:     if (w_byte_done) w_state_nxt = w_addr_ok ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: if (w_scl_fall && r_ack_phase) w_state_nxt = r_rw ? ST_RD_DATA : ST_WR_DATA;
                ST_WR_DATA:  if (w_byte_done) w_state_nxt = ST_WR_ACK;
                ST_WR_ACK:   if (w_scl_fall && r_ack_phase)
                                 w_state_nxt = (r_reg_ptr < LP_NUM_REGS) ? ST_WR_DATA : ST_IGNORE;
                ST_RD_DATA:  if (w_scl_fall && (r_bit_cnt == 4'd8)) w_state_nxt = ST_RD_ACK;
                ST_RD_ACK: begin
                    if (w_scl_rise && !r_ack_phase && !w_rd_continue) w_state_nxt = ST_IGNORE;
                    else if (w_scl_fall && r_ack_phase)                w_state_nxt = ST_RD_DATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_sda_oe_nxt = r_sda_oe;
        w_commit     = 1'b0;
        w_err_set    = 1'b0;
        if (w_start || w_stop) begin
            w_sda_oe_nxt = 1'b0;
            w_err_set    = w_in_byte;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    w_sda_oe_nxt = 1'b0;
                    w_err_set    = w_byte_done && !w_addr_ok;
                end
                ST_WR_DATA: begin
                    w_sda_oe_nxt = 1'b0;
                    w_commit     = w_byte_done;
                end
                ST_ADDR_ACK, ST_WR_ACK, ST_RD_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_phase && (r_state != ST_RD_ACK)) w_sda_oe_nxt = 1'b1;
                        else if (w_load_rd)                          w_sda_oe_nxt = ~w_ptr_byte[7];
                        else                                         w_sda_oe_nxt = 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    if (w_scl_fall) w_sda_oe_nxt = (r_bit_cnt == 4'd8) ? 1'b0 : ~r_shift[7];
                end
                default: w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt     <= 4'd0;
            r_ack_phase   <= 1'b0;
            r_shift       <= '0;
            r_rw          <= 1'b0;
            r_reg_ptr     <= 7'd0;
            r_sda_oe      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_error <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
        end else begin
            r_sda_oe <= w_sda_oe_nxt;
            r_wr_en  <= w_commit;
            if (w_commit) begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (r_reg_ptr == 7'(i)) r_regs[i] <= w_byte;
                r_wr_addr <= r_reg_ptr[5:0];
                r_wr_data <= w_byte;
                r_reg_ptr <= w_ptr_inc;
            end
            if (w_start)     r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;
            if (w_err_set)        r_frame_error <= 1'b1;
            else if (clear_error) r_frame_error <= 1'b0;

            if (w_start || w_stop || (w_state_nxt != r_state)) begin
                r_bit_cnt   <= 4'd0;
                r_ack_phase <= 1'b0;
            end else begin
                if (w_scl_rise && ((r_state == ST_ADDR) || (r_state == ST_WR_DATA) || (r_state == ST_RD_DATA)))
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                if (w_scl_fall && ((r_state == ST_ADDR_ACK) || (r_state == ST_WR_ACK)))
                    r_ack_phase <= 1'b1;
                if (w_scl_rise && (r_state == ST_RD_ACK))
                    r_ack_phase <= 1'b1;
            end

            if (w_load_rd)       r_shift <= w_ptr_byte;
            else if (w_scl_rise) r_shift <= w_byte;

            if ((r_state == ST_ADDR) && w_byte_done && !w_start && !w_stop) begin
                r_rw      <= w_sda;
                r_reg_ptr <= w_addr_ptr;
            end
            if ((r_state == ST_RD_ACK) && w_scl_rise && !r_ack_phase && w_rd_continue && !w_start && !w_stop)
                r_reg_ptr <= w_ptr_inc;
        end
    end

    assign sda_oe      = r_sda_oe;
    assign cfg_rd_data = w_cfg_byte;
    assign reg_wr_en   = r_wr_en;
    assign reg_wr_addr = r_wr_addr;
    assign reg_wr_data = r_wr_data;
    assign busy        = r_busy;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_i2c_lcm_register_responder.sv
// Directed bench: bit-banged master on an open-drain SDA line against the LCM register responder.
module tb_i2c_lcm_register_responder;

    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic       clear_error;
    logic [5:0] cfg_rd_addr;
    logic [7:0] cfg_rd_data;
    logic       reg_wr_en;
    logic [5:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;
    logic       frame_error;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    logic [5:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_lcm_register_responder #(.NUM_REGS(25), .RESET_VALUE(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .scl_in      (scl),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .clear_error (clear_error),
        .cfg_rd_addr (cfg_rd_addr),
        .cfg_rd_data (cfg_rd_data),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .busy        (busy),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_cnt++;
            last_wr_addr = reg_wr_addr;
            last_wr_data = reg_wr_data;
        end
    end

    task automatic bit_clk(input logic b, output logic s);
        sda_m = b; #(Q);
        scl = 1'b1; #(Q);
        s = sda_line; #(Q);
        scl = 1'b0; #(Q);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; #(Q);
        scl = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl = 1'b0; #(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; #(Q);
        scl = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_clk(b[i], s);
        bit_clk(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_clk(1'b1, s);
            d[i] = s;
        end
        bit_clk(mack, s);
    endtask

    task automatic read_reg(input logic [5:0] a, output logic [7:0] d);
        cfg_rd_addr = a; #1;
        d = cfg_rd_data;
    endtask

    task automatic pulse_clear;
        @(posedge clk); #1 clear_error = 1'b1;
        @(posedge clk); #1 clear_error = 1'b0;
        #2;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        #50;
        n_checks++; if (sda_oe !== 1'b0)      $display("FAIL rst_sda_oe: got %b want 0", sda_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0)        $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (frame_error !== 1'b0) $display("FAIL rst_ferr: got %b want 0", frame_error); else n_pass++;
        n_checks++; if (reg_wr_en !== 1'b0 || reg_wr_addr !== 6'h00 || reg_wr_data !== 8'h00)
            $display("FAIL rst_wr_port: got en=%b a=%h d=%h want 0/00/00", reg_wr_en, reg_wr_addr, reg_wr_data); else n_pass++;
        read_reg(6'h04, d);
        n_checks++; if (d !== 8'h00) $display("FAIL rst_reg04: got %h want 00", d); else n_pass++;
        reset = 1'b1; #(Q);
        read_reg(6'h3F, d);
        n_checks++; if (d !== 8'h00) $display("FAIL rst_oob_read: got %h want 00", d); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy_after: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_write;
        logic a0, a1;
        logic [7:0] d;
        i2c_start;
        n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy_start: got %b want 1", busy); else n_pass++;
        send_byte(8'h08, a0);
        send_byte(8'h3F, a1);
        n_checks++; if (a0 !== 1'b0 || a1 !== 1'b0) $display("FAIL wr_acks: got %b%b want 00", a0, a1); else n_pass++;
        i2c_stop;
        n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_stop: got %b want 0", busy); else n_pass++;
        n_checks++; if (wr_cnt !== 1 || last_wr_addr !== 6'h04 || last_wr_data !== 8'h3F)
            $display("FAIL wr_pulse: got cnt=%0d a=%h d=%h want 1/04/3f", wr_cnt, last_wr_addr, last_wr_data); else n_pass++;
        read_reg(6'h04, d);
        n_checks++; if (d !== 8'h3F) $display("FAIL wr_reg04: got %h want 3f", d); else n_pass++;
        n_checks++; if (frame_error !== 1'b0) $display("FAIL wr_ferr: got %b want 0", frame_error); else n_pass++;
    endtask

    task automatic test_read;
        logic a0;
        logic [7:0] d, r;
        i2c_start;
        send_byte(8'h09, a0);
        recv_byte(1'b1, d);
        i2c_stop;
        n_checks++; if (a0 !== 1'b0) $display("FAIL rd_addr_ack: got %b want 0", a0); else n_pass++;
        n_checks++; if (d !== 8'h3F) $display("FAIL rd_data: got %h want 3f", d); else n_pass++;
        read_reg(6'h04, r);
        n_checks++; if (r !== 8'h3F || wr_cnt !== 1) $display("FAIL rd_no_side_effect: got reg=%h cnt=%0d want 3f/1", r, wr_cnt); else n_pass++;
        n_checks++; if (frame_error !== 1'b0) $display("FAIL rd_ferr: got %b want 0", frame_error); else n_pass++;
    endtask

    task automatic test_burst;
        logic a0, a1, a2, a3;
        logic [7:0] d0, d1, r;
        i2c_start;
        send_byte(8'h2E, a0);
        send_byte(8'h99, a1);
        send_byte(8'h08, a2);
        send_byte(8'h55, a3);
        i2c_stop;
        n_checks++; if ({a0, a1, a2, a3} !== 4'b0001) $display("FAIL burst_acks: got %b want 0001", {a0, a1, a2, a3}); else n_pass++;
        n_checks++; if (wr_cnt !== 3 || last_wr_addr !== 6'h18 || last_wr_data !== 8'h08)
            $display("FAIL burst_writes: got cnt=%0d a=%h d=%h want 3/18/08", wr_cnt, last_wr_addr, last_wr_data); else n_pass++;
        read_reg(6'h17, r);
        n_checks++; if (r !== 8'h99) $display("FAIL burst_reg17: got %h want 99", r); else n_pass++;
        read_reg(6'h18, r);
        n_checks++; if (r !== 8'h08) $display("FAIL burst_reg18: got %h want 08", r); else n_pass++;
        read_reg(6'h19, r);
        n_checks++; if (r !== 8'h00) $display("FAIL burst_reg19: got %h want 00", r); else n_pass++;
        n_checks++; if (frame_error !== 1'b0) $display("FAIL burst_ferr: got %b want 0", frame_error); else n_pass++;
        i2c_start;
        send_byte(8'h2F, a0);
        recv_byte(1'b0, d0);
        recv_byte(1'b1, d1);
        i2c_stop;
        n_checks++; if (a0 !== 1'b0 || d0 !== 8'h99 || d1 !== 8'h08)
            $display("FAIL burst_read: got ack=%b %h %h want 0 99 08", a0, d0, d1); else n_pass++;
    endtask

    task automatic test_bad_addr;
        logic a0;
        i2c_start;
        send_byte(8'h32, a0);
        i2c_stop;
        n_checks++; if (a0 !== 1'b1) $display("FAIL bad_addr_nack: got %b want 1", a0); else n_pass++;
        n_checks++; if (frame_error !== 1'b1) $display("FAIL bad_addr_ferr: got %b want 1", frame_error); else n_pass++;
        n_checks++; if (wr_cnt !== 3) $display("FAIL bad_addr_nowrite: got %0d want 3", wr_cnt); else n_pass++;
        pulse_clear;
        n_checks++; if (frame_error !== 1'b0) $display("FAIL bad_addr_clear: got %b want 0", frame_error); else n_pass++;
        i2c_start;
        send_byte(8'h88, a0);
        i2c_stop;
        n_checks++; if (a0 !== 1'b1 || frame_error !== 1'b1)
            $display("FAIL msb_addr_nack: got ack=%b ferr=%b want 1/1", a0, frame_error); else n_pass++;
        pulse_clear;
    endtask

    task automatic test_partial;
        logic a0, a1, s;
        logic [7:0] r;
        i2c_start;
        send_byte(8'h08, a0);
        bit_clk(1'b1, s); bit_clk(1'b0, s); bit_clk(1'b1, s); bit_clk(1'b0, s);
        i2c_stop;
        n_checks++; if (wr_cnt !== 3 || frame_error !== 1'b1)
            $display("FAIL partial_stop: got cnt=%0d ferr=%b want 3/1", wr_cnt, frame_error); else n_pass++;
        read_reg(6'h04, r);
        n_checks++; if (r !== 8'h3F) $display("FAIL partial_reg04: got %h want 3f", r); else n_pass++;
        pulse_clear;
        i2c_start;
        send_byte(8'h08, a0);
        bit_clk(1'b0, s); bit_clk(1'b1, s);
        i2c_start;
        n_checks++; if (frame_error !== 1'b1 || busy !== 1'b1)
            $display("FAIL rep_start: got ferr=%b busy=%b want 1/1", frame_error, busy); else n_pass++;
        send_byte(8'h0A, a0);
        send_byte(8'h5A, a1);
        i2c_stop;
        n_checks++; if (a0 !== 1'b0 || a1 !== 1'b0) $display("FAIL rep_start_acks: got %b%b want 00", a0, a1); else n_pass++;
        n_checks++; if (wr_cnt !== 4 || last_wr_addr !== 6'h05 || last_wr_data !== 8'h5A)
            $display("FAIL rep_start_write: got cnt=%0d a=%h d=%h want 4/05/5a", wr_cnt, last_wr_addr, last_wr_data); else n_pass++;
        read_reg(6'h05, r);
        n_checks++; if (r !== 8'h5A) $display("FAIL rep_start_reg05: got %h want 5a", r); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        logic a0, s;
        logic [7:0] r;
        i2c_start;
        send_byte(8'h0A, a0);
        bit_clk(1'b1, s); bit_clk(1'b1, s); bit_clk(1'b0, s);
        scl = 1'b1; #(Q / 2);
        n_checks++; if (busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b want 1", busy); else n_pass++;
        reset = 1'b0; #1;
        n_checks++; if (sda_oe !== 1'b0 || busy !== 1'b0 || frame_error !== 1'b0)
            $display("FAIL midrst_outputs: got oe=%b busy=%b ferr=%b want 0/0/0", sda_oe, busy, frame_error); else n_pass++;
        read_reg(6'h04, r);
        n_checks++; if (r !== 8'h00) $display("FAIL midrst_reg04: got %h want 00", r); else n_pass++;
        read_reg(6'h17, r);
        n_checks++; if (r !== 8'h00) $display("FAIL midrst_reg17: got %h want 00", r); else n_pass++;
        n_checks++; if (reg_wr_addr !== 6'h00 || reg_wr_data !== 8'h00)
            $display("FAIL midrst_wr_port: got a=%h d=%h want 00/00", reg_wr_addr, reg_wr_data); else n_pass++;
        sda_m = 1'b1; #(Q);
        reset = 1'b1; #(Q);
    endtask

    initial begin
        reset       = 1'b0;
        scl         = 1'b1;
        sda_m       = 1'b1;
        clear_error = 1'b0;
        cfg_rd_addr = 6'h00;
        test_reset;
        test_write;
        test_read;
        test_burst;
        test_bad_addr;
        test_partial;
        test_reset_midframe;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
